// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// Module : game_pkg
// Shared state encoding, LFSR taps and lane helpers for the obstacle sequencer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_GAP    = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 as taps on bits 7, 5, 4, 3 of a left shifter
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [6:0] ALL_LANES = 7'b0101010;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [1:0] lane_from_lfsr(input logic [7:0] v);
    return (v[1:0] == 2'd3) ? 2'd1 : v[1:0];
  endfunction

  function automatic logic [6:0] lane_bit(input logic [1:0] lane);
    return 7'd1 << {lane, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ----------------------------------------------------------------------------
// Module : tick_prescaler
// Divides the clock down to a one-cycle game tick; parked at zero while idle.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic Clk,
  input  logic Clr,
  input  logic en,
  input  logic clr_cnt,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_cnt <= '0;
    end else if (!en || clr_cnt) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = en && (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/obstacle_scheduler.sv
// ----------------------------------------------------------------------------
// Module : obstacle_scheduler
// Round sequencer: blink a random lane, hold it solid, score or take a life.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int         TICK_DIV     = 25000000,
  parameter int         WARN_TICKS   = 2,
  parameter int         ACTIVE_TICKS = 3,
  parameter int         GAP_TICKS    = 1,
  parameter int         LIVES        = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       Clk,
  input  logic       Clr,
  input  logic       Start,
  input  logic [6:0] Player,
  output logic [6:0] obstacle,
  output logic       hit,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       tick
);

  localparam logic [7:0] C_WARN_LAST   = 8'(WARN_TICKS - 1);
  localparam logic [7:0] C_ACTIVE_LAST = 8'(ACTIVE_TICKS - 1);
  localparam logic [7:0] C_GAP_LAST    = 8'(GAP_TICKS - 1);
  localparam logic [1:0] C_LIVES       = 2'(LIVES);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_lfsr;
  logic [1:0] r_lane;
  logic       r_blink;
  logic       r_hit_flag;
  logic       r_hit;
  logic [7:0] r_score;
  logic [1:0] r_lives;
  logic [7:0] r_tcnt;

  logic       w_en;
  logic       w_start_acc;
  logic       w_tick;
  logic       w_phase_done;
  logic       w_collision;
  logic [6:0] w_obstacle;

  assign w_en        = (r_state == ST_WARN) || (r_state == ST_ACTIVE) || (r_state == ST_GAP);
  assign w_start_acc = Start && ((r_state == ST_IDLE) || (r_state == ST_OVER));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clk     (Clk),
    .Clr     (Clr),
    .en      (w_en),
    .clr_cnt (w_start_acc),
    .tick    (w_tick)
  );

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_obstacle   = '0;
    w_collision  = 1'b0;
    w_phase_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) w_next = ST_WARN;
      end
      ST_WARN: begin
        w_obstacle   = r_blink ? lane_bit(r_lane) : 7'd0;
        w_phase_done = w_tick && (r_tcnt == C_WARN_LAST);
        if (w_phase_done) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_obstacle   = lane_bit(r_lane);
        w_collision  = Player[{r_lane, 1'b0}] && !r_hit_flag;
        w_phase_done = w_tick && (r_tcnt == C_ACTIVE_LAST);
        // Losing the last life wins over the end-of-round transition
        if (w_collision && (r_lives == 2'd1)) w_next = ST_OVER;
        else if (w_phase_done)                 w_next = ST_GAP;
      end
      ST_GAP: begin
        w_phase_done = w_tick && (r_tcnt == C_GAP_LAST);
        if (w_phase_done) w_next = ST_WARN;
      end
      ST_OVER: begin
        w_obstacle = ALL_LANES;
        if (w_start_acc) w_next = ST_WARN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_lfsr     <= LFSR_SEED;
      r_lane     <= '0;
      r_blink    <= 1'b0;
      r_hit_flag <= 1'b0;
      r_hit      <= 1'b0;
      r_score    <= '0;
      r_lives    <= C_LIVES;
      r_tcnt     <= '0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      r_hit  <= w_collision;
      if (w_start_acc) begin
        r_lives    <= C_LIVES;
        r_score    <= '0;
        r_lane     <= lane_from_lfsr(r_lfsr);
        r_hit_flag <= 1'b0;
        r_blink    <= 1'b1;
        r_tcnt     <= '0;
      end else begin
        if (w_tick) r_tcnt <= w_phase_done ? 8'd0 : r_tcnt + 8'd1;
        if ((r_state == ST_WARN) && w_tick) r_blink <= ~r_blink;
        if (w_collision) begin
          r_lives    <= r_lives - 2'd1;
          r_hit_flag <= 1'b1;
        end
        if ((r_state == ST_ACTIVE) && w_phase_done && !r_hit_flag && !w_collision
            && (r_score != 8'hFF)) begin
          r_score <= r_score + 8'd1;
        end
        if ((r_state == ST_GAP) && w_phase_done) begin
          r_lane     <= lane_from_lfsr(r_lfsr);
          r_hit_flag <= 1'b0;
          r_blink    <= 1'b1;
        end
      end
    end
  end

  assign obstacle  = w_obstacle;
  assign hit       = r_hit;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = (r_state == ST_OVER);
  assign tick      = w_tick;

endmodule

`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
// ----------------------------------------------------------------------------
// Module : tb_obstacle_scheduler
// Directed checks of round timing, collisions, lives, score and lane sequence.
// Rev    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_obstacle_scheduler;

  logic       Clk = 1'b0;
  logic       Clr;
  logic       Start;
  logic [6:0] Player;
  logic [6:0] obstacle;
  logic       hit;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       tick;

  always #5 Clk = ~Clk;

  obstacle_scheduler #(
    .TICK_DIV     (4),
    .WARN_TICKS   (2),
    .ACTIVE_TICKS (3),
    .GAP_TICKS    (1),
    .LIVES        (3),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .Start     (Start),
    .Player    (Player),
    .obstacle  (obstacle),
    .hit       (hit),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .tick      (tick)
  );

  // Reference LFSR; m_prev holds the value the design saw before the last edge
  logic [7:0] m_lfsr;
  logic [7:0] m_prev;
  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score;
  int exp_lives;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] lane_mask(input logic [7:0] v);
    logic [1:0] l;
    logic [6:0] m;
    l = v[1:0];
    if (l == 2'd3) l = 2'd1;
    m = '0;
    m[2*l+1] = 1'b1;
    return m;
  endfunction

  // Starts at WARN cycle 0, ends at the next round's WARN cycle 0.
  // mode: 0 idle player, 1 on lane during WARN, 2 on lane in ACTIVE,
  //       3 other lanes in ACTIVE, 4 all bits high in ACTIVE
  task automatic play_round(input int mode);
    logic [6:0] bitm, sel, warn_pl, act_pl, exp_obs;
    bit         exp_hit;
    int         hits;
    bitm    = lane_mask(m_prev);
    sel     = bitm >> 1;
    warn_pl = (mode == 1) ? sel : 7'd0;
    act_pl  = (mode == 2) ? sel : (mode == 3) ? (7'b0010101 & ~sel) :
              (mode == 4) ? 7'h7F : 7'd0;
    exp_hit = (mode == 2) || (mode == 4);
    hits    = 0;
    Player  = warn_pl;
    for (int c = 0; c < 24; c++) begin
      if (c < 4)       exp_obs = bitm;
      else if (c < 8)  exp_obs = 7'd0;
      else if (c < 20) exp_obs = bitm;
      else             exp_obs = 7'd0;
      check_value("obstacle", obstacle, exp_obs);
      check_value("tick", tick, (c % 4 == 3));
      if (hit) hits++;
      if (c == 7)  Player = act_pl;
      if (c == 19) Player = 7'd0;
      @(negedge Clk);
    end
    if (exp_hit)              exp_lives--;
    else if (exp_score < 255) exp_score++;
    check_value("hit_count", hits, exp_hit ? 1 : 0);
    check_value("score", score, exp_score);
    check_value("lives", lives, exp_lives);
    check_value("game_over", game_over, 0);
  endtask

  initial begin
    int over_at;
    logic [6:0] bitm;
    Clr    = 1'b1;
    Start  = 1'b0;
    Player = 7'd0;
    repeat (2) @(negedge Clk);
    check_value("rst_obstacle", obstacle, 0);
    check_value("rst_hit", hit, 0);
    check_value("rst_score", score, 0);
    check_value("rst_lives", lives, 3);
    check_value("rst_game_over", game_over, 0);
    check_value("rst_tick", tick, 0);
    Clr = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check_value("idle_obstacle", obstacle, 0);
      check_value("idle_tick", tick, 0);
    end

    // First game: clean, hit with Start held, warn-only, other lanes
    exp_score = 0;
    exp_lives = 3;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check_value("lane_onehot", ($countones(obstacle) == 1) && ((obstacle & 7'b1010101) == 0), 1);
    play_round(0);
    Start = 1'b1;
    play_round(2);
    Start = 1'b0;
    play_round(1);
    play_round(3);

    // Asynchronous clear mid-ACTIVE
    repeat (10) @(negedge Clk);
    check_value("pre_clr_active", (obstacle != 0), 1);
    #2 Clr = 1'b1;
    #1;
    check_value("clr_obstacle", obstacle, 0);
    check_value("clr_lives", lives, 3);
    check_value("clr_score", score, 0);
    check_value("clr_game_over", game_over, 0);
    @(negedge Clk);
    Clr = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      check_value("post_clr_obstacle", obstacle, 0);
      check_value("post_clr_tick", tick, 0);
    end

    // Lose all lives
    exp_score = 0;
    exp_lives = 3;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    play_round(2);
    play_round(4);
    bitm    = lane_mask(m_prev);
    over_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (game_over && over_at < 0) over_at = c;
      if (c == 7)  Player = bitm >> 1;
      if (c == 12) Player = 7'd0;
      @(negedge Clk);
    end
    check_value("over_cycle", over_at, 9);
    check_value("over_lives", lives, 0);
    check_value("over_obstacle", obstacle, 7'b0101010);
    check_value("over_game_over", game_over, 1);
    check_value("over_hit", hit, 0);
    check_value("over_tick", tick, 0);

    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    exp_score = 0;
    exp_lives = 3;
    check_value("restart_lives", lives, 3);
    check_value("restart_score", score, 0);
    check_value("restart_game_over", game_over, 0);
    check_value("restart_obstacle", obstacle, lane_mask(m_prev));

    // Saturation and long lane sequence
    for (int r = 0; r < 260; r++) play_round(0);
    check_value("score_saturated", score, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
